lram_fb_arbiter: RTL
====================

// Module: lram_fb_arbiter
// PURPOSE
//  Shares the single lram_fb frame buffer between NUM_WR write requesters (camera, overlay)
//  and NUM_RD read requesters (display, SPI readback).
//  - Sequences LRAM start-up: waits for lramready, then optionally clears the whole buffer.
//  - Round-robin arbitrates each port independently; write and read ports are used in parallel.
//  - Routes in-order read data back to the requester that issued it.
// PARAMETERS
//  NUM_WR      2      number of write requesters (1..4)
//  NUM_RD      2      number of read requesters (1..4)
//  ADDR_W      16     LRAM word address width
//  DATA_W      32     LRAM data width
//  DEPTH       65536  words swept by the optional clear (<= 2**ADDR_W)
//  MAX_OUTST   4      max reads in flight; depth of the tag FIFO (power of 2)
// PORTS
//  clk              in   1               system clock, same clock as lram_fb
//  reset_n          in   1               asynchronous active-low reset
//  wr_req_i         in   NUM_WR          per-writer request; held until granted
//  wr_addr_i        in   NUM_WR*ADDR_W   packed write addresses, writer k at [k*ADDR_W +: ADDR_W]
//  wr_data_i        in   NUM_WR*DATA_W   packed write data
//  wr_ben_i         in   NUM_WR*4        packed byte enables
//  wr_gnt_o         out  NUM_WR          one-hot 1-cycle grant
//  rd_req_i         in   NUM_RD          per-reader request; held until granted
//  rd_addr_i        in   NUM_RD*ADDR_W   packed read addresses
//  rd_gnt_o         out  NUM_RD          one-hot 1-cycle grant
//  rd_data_o        out  DATA_W          read data, broadcast to all readers
//  rd_valid_o       out  NUM_RD          one-hot: rd_data_o belongs to reader k
//  ready_o          out  1               high once init (and clear) complete
//  err_o            out  1               sticky: LRAM valid with no outstanding read
//  lram_ready_i     in   1               lram_fb lramready_o
//  lram_wr_en_o     out  1               to lram_fb wr_en_i
//  lram_wr_addr_o   out  ADDR_W          to lram_fb wr_addr_i
//  lram_wr_data_o   out  DATA_W          to lram_fb wr_data_i
//  lram_ben_o       out  4               to lram_fb ben_i
//  lram_rd_en_o     out  1               read issue strobe (to rd_clk_en_i qualifier)
//  lram_rd_addr_o   out  ADDR_W          to lram_fb rd_addr_i
//  lram_rd_data_i   in   DATA_W          lram_fb rd_data_o
//  lram_rd_valid_i  in   1               lram_fb rd_datavalid_o
// BEHAVIOUR
//  - Reset: all outputs 0; state INIT; RR pointers 0; tag FIFO empty; err_o 0.
//  - FSM: INIT -> (lram_ready_i=1) -> CLEAR (macro on) or RUN (macro off).
//    CLEAR -> RUN after the last word is written. RUN is held until reset.
//  - ready_o is registered; asserted the cycle the FSM enters RUN.
//    No grants are issued outside RUN, requests are simply held.
//  - Write arbitration (RUN): each cycle, grant the first requester at or after wr_ptr,
//    wrapping modulo NUM_WR.
//    wr_gnt_o[k] is a 1-cycle pulse. The cycle after the grant, the LRAM write is driven:
//    lram_wr_en_o=1 with the captured addr/data/ben.
//    wr_ptr becomes k+1 mod NUM_WR, so a continuously requesting writer gets at most
//    every NUM_WR-th slot when others also request.
//    Requester drops or changes its request the cycle after the grant.
//  - Read arbitration: same RR scheme on rd_ptr. A grant requires tag FIFO not full.
//    Grant cycle: push reader index. Next cycle: lram_rd_en_o=1, lram_rd_addr_o=addr.
//    One read is issued per cycle, back-to-back allowed.
//  - Read return: on lram_rd_valid_i with FIFO non-empty, pop tag t.
//    Next cycle: rd_valid_o[t]=1 and rd_data_o=registered lram_rd_data_i (1-cycle latency).
//    Returns are in issue order.
//  - Simultaneous read grant (push) and return (pop) in one cycle: both happen; count unchanged.
//    When full, a same-cycle pop does NOT allow a grant (registered full flag).
//  - lram_rd_valid_i with FIFO empty: data dropped, err_o set (sticky until reset).
//  - Write and read ports are independent; the same address in the same cycle is not
//    ordered by this block.
//  - Reset mid-operation: everything clears immediately (async), in-flight reads discarded.
//    Later stray valids set err_o.
//  - lram_wr_en_o and lram_rd_en_o are 0 whenever no grant happened in the previous cycle.
// CONFIGURATION
//  LRAM_FB_ARBITER_CLEAR_EN defined:
//   - After INIT, the CLEAR state writes DATA_W'0 with ben 4'hF to addresses 0..DEPTH-1,
//     one per cycle.
//   - No grants are issued during CLEAR. ready_o rises the cycle after the final write.
//  Not defined: CLEAR is absent; INIT goes directly to RUN.
// TESTING
//  1 lram_ready_i=0 for 100 cycles with wr_req_i=2'b01 -> no wr_gnt_o, ready_o=0;
//    ready_i=1 -> ready_o=1 next cycle (macro off).
//  2 Writer0 req, addr 16'h4753, data 32'h0000FFFF, ben 4'b0001 -> wr_gnt_o=01 one cycle;
//    next cycle lram_wr_en_o=1 with those values; then 0.
//  3 Both writers request continuously -> wr_gnt_o sequence 01,10,01,10;
//    exactly one lram write per cycle.
//  4 Reader1 issues 5 reads, LRAM valid withheld -> 4 grants, 5th held until the first valid;
//    each return gives rd_valid_o=2'b10, data in issue order.
//  5 Macro on, DEPTH=16 -> 16 writes of 0 to addresses 0..15, ben F;
//    ready_o=1 the cycle after addr 15; requests ignored until then.
//  6 reset_n low with 2 reads outstanding -> all outputs 0; after release, a stray
//    lram_rd_valid_i sets err_o=1 and no rd_valid_o.

Source files
------------

// File: rtl/lram_fb_arbiter.sv
// Arbiter sharing the lram_fb frame buffer between round-robin write and read requesters.
// Define LRAM_FB_ARBITER_CLEAR_EN to zero-fill words 0..DEPTH-1 before entering RUN.
module lram_fb_arbiter #(
    parameter int NUM_WR    = 2,
    parameter int NUM_RD    = 2,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 65536,
    parameter int MAX_OUTST = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_WR-1:0]        wr_req_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic [NUM_WR*4-1:0]      wr_ben_i,
    output logic [NUM_WR-1:0]        wr_gnt_o,
    input  logic [NUM_RD-1:0]        rd_req_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD-1:0]        rd_gnt_o,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic [NUM_RD-1:0]        rd_valid_o,
    output logic                     ready_o,
    output logic                     err_o,
    input  logic                     lram_ready_i,
    output logic                     lram_wr_en_o,
    output logic [ADDR_W-1:0]        lram_wr_addr_o,
    output logic [DATA_W-1:0]        lram_wr_data_o,
    output logic [3:0]               lram_ben_o,
    output logic                     lram_rd_en_o,
    output logic [ADDR_W-1:0]        lram_rd_addr_o,
    input  logic [DATA_W-1:0]        lram_rd_data_i,
    input  logic                     lram_rd_valid_i
);
    localparam int WP_W  = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
    localparam int RP_W  = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int FP_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = FP_W + 1;

    typedef enum logic [1:0] {ST_INIT, ST_CLEAR, ST_RUN} state_e;

    state_e state_q, state_d;
    logic [WP_W-1:0]   wr_ptr_q;
    logic [RP_W-1:0]   rd_ptr_q;
    logic              ready_q, err_q;
    logic              wr_en_q, rd_en_q;
    logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
    logic [DATA_W-1:0] wr_data_q, rd_data_q;
    logic [3:0]        wr_ben_q;
    logic [NUM_RD-1:0] rd_valid_q;
    logic [RP_W-1:0]   tag_mem_q [MAX_OUTST];
    logic [FP_W-1:0]   tag_wptr_q, tag_rptr_q;
    logic [CNT_W-1:0]  tag_cnt_q;
`ifdef LRAM_FB_ARBITER_CLEAR_EN
    logic [ADDR_W:0]   clr_cnt_q;
`endif

    logic              wr_hit, rd_hit, rd_go, tag_full, tag_empty, tag_pop;
    logic [WP_W-1:0]   wr_idx;
    logic [RP_W-1:0]   rd_idx;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                if (lram_ready_i) begin
`ifdef LRAM_FB_ARBITER_CLEAR_EN
                    state_d = ST_CLEAR;
`else
                    state_d = ST_RUN;
`endif
                end
            end
            ST_CLEAR: begin
`ifdef LRAM_FB_ARBITER_CLEAR_EN
                // One idle cycle after the last clear write so ready_o trails it.
                if (int'(clr_cnt_q) >= DEPTH) state_d = ST_RUN;
`else
                state_d = ST_RUN;
`endif
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        wr_hit = 1'b0;
        wr_idx = '0;
        rd_hit = 1'b0;
        rd_idx = '0;
        if (state_q == ST_RUN) begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (!wr_hit && wr_req_i[(int'(wr_ptr_q) + i) % NUM_WR]) begin
                    wr_hit = 1'b1;
                    wr_idx = WP_W'((int'(wr_ptr_q) + i) % NUM_WR);
                end
            end
            for (int i = 0; i < NUM_RD; i++) begin
                if (!rd_hit && rd_req_i[(int'(rd_ptr_q) + i) % NUM_RD]) begin
                    rd_hit = 1'b1;
                    rd_idx = RP_W'((int'(rd_ptr_q) + i) % NUM_RD);
                end
            end
        end
    end

    assign tag_full  = (tag_cnt_q == CNT_W'(MAX_OUTST));
    assign tag_empty = (tag_cnt_q == '0);
    assign rd_go     = rd_hit && !tag_full;
    assign tag_pop   = lram_rd_valid_i && !tag_empty;

    always_comb begin
        wr_gnt_o = '0;
        rd_gnt_o = '0;
        if (wr_hit) wr_gnt_o[wr_idx] = 1'b1;
        if (rd_go)  rd_gnt_o[rd_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_INIT;
            ready_q   <= 1'b0;
            wr_ptr_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_ben_q  <= '0;
`ifdef LRAM_FB_ARBITER_CLEAR_EN
            clr_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_RUN);
            wr_en_q <= 1'b0;
            if (wr_hit) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= wr_addr_i[wr_idx*ADDR_W +: ADDR_W];
                wr_data_q <= wr_data_i[wr_idx*DATA_W +: DATA_W];
                wr_ben_q  <= wr_ben_i[wr_idx*4 +: 4];
                wr_ptr_q  <= (int'(wr_idx) == NUM_WR - 1) ? '0 : wr_idx + 1'b1;
            end
`ifdef LRAM_FB_ARBITER_CLEAR_EN
            if (state_q == ST_CLEAR && int'(clr_cnt_q) < DEPTH) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= clr_cnt_q[ADDR_W-1:0];
                wr_data_q <= '0;
                wr_ben_q  <= 4'hF;
                clr_cnt_q <= clr_cnt_q + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rd_go) tag_mem_q[tag_wptr_q] <= rd_idx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q   <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            tag_wptr_q <= '0;
            tag_rptr_q <= '0;
            tag_cnt_q  <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            rd_en_q    <= rd_go;
            rd_valid_q <= '0;
            if (rd_go) begin
                rd_addr_q  <= rd_addr_i[rd_idx*ADDR_W +: ADDR_W];
                rd_ptr_q   <= (int'(rd_idx) == NUM_RD - 1) ? '0 : rd_idx + 1'b1;
                tag_wptr_q <= (int'(tag_wptr_q) == MAX_OUTST - 1) ? '0 : tag_wptr_q + 1'b1;
            end
            if (tag_pop) begin
                rd_valid_q[tag_mem_q[tag_rptr_q]] <= 1'b1;
                rd_data_q  <= lram_rd_data_i;
                tag_rptr_q <= (int'(tag_rptr_q) == MAX_OUTST - 1) ? '0 : tag_rptr_q + 1'b1;
            end
            if (rd_go && !tag_pop)      tag_cnt_q <= tag_cnt_q + 1'b1;
            else if (!rd_go && tag_pop) tag_cnt_q <= tag_cnt_q - 1'b1;
            // A return with nothing outstanding cannot be routed; flag it until reset.
            if (lram_rd_valid_i && tag_empty) err_q <= 1'b1;
        end
    end

    assign ready_o        = ready_q;
    assign err_o          = err_q;
    assign lram_wr_en_o   = wr_en_q;
    assign lram_wr_addr_o = wr_addr_q;
    assign lram_wr_data_o = wr_data_q;
    assign lram_ben_o     = wr_ben_q;
    assign lram_rd_en_o   = rd_en_q;
    assign lram_rd_addr_o = rd_addr_q;
    assign rd_valid_o     = rd_valid_q;
    assign rd_data_o      = rd_data_q;
endmodule
